motor_seq: RTL
==============

# motor_seq

Clocked sequencer for the two-direction limit-switch motor drive (left drive `a`, right drive `b`, end switches `fe`/`fd`, requesters `l`/`u`). It replaces direct combinational drive with a Moore state machine. The state machine adds a guaranteed brake (dead-time) interval on every stop or reversal, never asserts both drives at once, and can optionally trip a travel-timeout fault. It sits between the request/switch inputs and the motor driver pins.

## Interface
- `DEAD_CYCLES`, 4: brake interval length in clock cycles, with both drives off; must be ≥1.
- `TIMEOUT_CYCLES`, 1000: maximum cycles allowed in a run state before a fault; used only with the macro.
- `CNT_W`, 16: counter width; must hold max(DEAD_CYCLES, TIMEOUT_CYCLES).
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `l`  in  1  local request: drive right toward `fd`.
- `u`  in  1  remote request: same meaning as `l`, OR-ed with it (`req = l | u`).
- `fe`  in  1  left end switch, 1 = at left end.
- `fd`  in  1  right end switch, 1 = at right end.
- `a`  out  1  left drive.
- `b`  out  1  right drive.
- `busy`  out  1  high in RUN_L, RUN_R and DEAD.
- `fault`  out  1  travel timeout tripped; constant 0 without the macro.

## Operation
- States: STOP, RUN_R, RUN_L, DEAD, FAULT (FAULT exists only with the macro).
- Moore outputs: `a` = (state==RUN_L), `b` = (state==RUN_R), `fault` = (state==FAULT). `a` and `b` are never high together.
- STOP: if `req & ~fd` → RUN_R; else if `~req & ~fe` → RUN_L; else stay in STOP.
- RUN_R: if `fd` or `~req` → DEAD.
- RUN_L: if `fe` or `req` → DEAD.
- DEAD: counter loads 0 on entry. The state lasts exactly DEAD_CYCLES cycles, then → STOP. Inputs are ignored during DEAD.
- Any stop or reversal therefore costs DEAD_CYCLES + 1 cycles with both drives at 0 before the opposite drive asserts (the DEAD cycles plus one STOP cycle).
- `fe` and `fd` both 1 (sensor conflict): STOP stays in STOP. A run state exits to DEAD on its own direction's switch, so it also ends up stopped.
- Inputs are sampled raw; synchronisation and debouncing belong to the caller.

## Timing
- Reset: state=STOP and the counter is cleared. `a`, `b`, `busy` and `fault` are 0 from the first edge with `rst`=1.
- `rst` overrides everything, including an active RUN or FAULT; the drive drops at that edge.
- Latency: a condition present before edge k takes effect from edge k. Example: `l` rises, then `b`=1 after the next edge.
- Stop latency: `fd` seen before edge k gives `b`=0 after edge k.
- Counter arithmetic is unsigned, CNT_W bits, and saturates. There is no wrap-around.

## Configuration
- Macro `MOTOR_SEQ_TIMEOUT_EN`.
- Defined:
  - The run counter clears on entry to RUN_R/RUN_L and increments each run cycle.
  - When it reaches TIMEOUT_CYCLES with no exit condition, the next state is FAULT: `a`=`b`=0, `fault`=1, `busy`=0.
  - FAULT is left only via `rst`.
  - If an exit condition and the timeout coincide on the same edge, the exit condition wins and the next state is DEAD.
- Undefined: no FAULT state and no run counter. `fault` is tied to 0, and a run state can last indefinitely.

## Structure
- Package `motor_seq_pkg`:
  - `state_t` enum (STOP, RUN_R, RUN_L, DEAD, FAULT).
  - Default constants for DEAD_CYCLES and TIMEOUT_CYCLES.
- Sub-module `dead_timer`, instanced once:
  - Ports: `clk`, `rst`, `start`, `done`; parameter DEAD_CYCLES.
  - `done` pulses on the final DEAD cycle.
- The timeout counter stays inline under the macro.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with `l`=1 → `a`=`b`=`busy`=`fault`=0. After `rst` falls, `b`=1 after 1 edge, provided `fd`=0.
- **Stop at right end:** `l`=1, `fe`=1, `fd`=0 → `b`=1. Raise `fd` → `b`=0 at the next edge, `busy`=1 for 4 cycles, then STOP with `a`=`b`=0.
- **Reversal:** RUN_R, then drop `l` and `u` with `fe`=0 → `b`=0. `a`=`b`=0 for exactly 5 cycles (4 DEAD + 1 STOP), then `a`=1.
- **Timeout:** macro on, TIMEOUT_CYCLES=10, `u`=1, `fd` held 0 → `b` high for 10 cycles, then `b`=0 and `fault`=1. The fault persists after `u`=0 and clears only with `rst`.
- **Sensor conflict:** `fe`=`fd`=1, toggle `l`/`u` → `a`=`b`=0 throughout, `busy`=0.
- **Reset mid-run:** `rst` asserted during RUN_L → `a`=0 at that edge; state is STOP after `rst` releases.

Source files
------------

// File: rtl/motor_seq_pkg.sv
// motor_seq_pkg: shared types and default constants for the motor sequencer.
//   state_t              - sequencer state encoding
//   DEF_DEAD_CYCLES      - default brake interval, in clock cycles
//   DEF_TIMEOUT_CYCLES   - default maximum run length before a fault
//   DEF_CNT_W            - default counter width
package motor_seq_pkg;

    typedef enum logic [2:0] {
        STOP  = 3'd0,
        RUN_R = 3'd1,
        RUN_L = 3'd2,
        DEAD  = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam int DEF_DEAD_CYCLES    = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1000;
    localparam int DEF_CNT_W          = 16;

endpackage

// File: rtl/dead_timer.sv
// dead_timer: measures the brake interval during which both drives are off.
//   clk   in  clock
//   rst   in  synchronous active-high reset
//   start in  high in the cycle before the first brake cycle; the counter
//             loads 0 at that edge
//   done  out high during the final brake cycle
module dead_timer
    import motor_seq_pkg::*;
#(
    parameter int DEAD_CYCLES = DEF_DEAD_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEAD_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             active;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // cnt holds the index (from 0) of the current brake cycle.
    assign done = active && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
        end else if (active) begin
            if (done) begin
                active <= 1'b0;
            end else begin
                cnt <= sat_inc(cnt);
            end
        end
    end

endmodule

// File: rtl/motor_seq.sv
// motor_seq: Moore sequencer for a two-direction limit-switch motor drive.
// Every stop or reversal passes through a brake interval with both drives
// off. The two drives are never asserted together.
// Optional feature macro: MOTOR_SEQ_TIMEOUT_EN (travel-timeout fault).
//   clk   in  clock
//   rst   in  synchronous active-high reset
//   l, u  in  requests, OR-ed: 1 = drive right toward fd, 0 = drive left
//   fe    in  left end switch (1 = at left end)
//   fd    in  right end switch (1 = at right end)
//   a     out left drive
//   b     out right drive
//   busy  out running or braking
//   fault out travel timeout tripped (0 when the macro is undefined)
module motor_seq
    import motor_seq_pkg::*;
#(
    parameter int DEAD_CYCLES    = DEF_DEAD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic l,
    input  logic u,
    input  logic fe,
    input  logic fd,
    output logic a,
    output logic b,
    output logic busy,
    output logic fault
);

    // Reject configurations the counters cannot represent.
    if (DEAD_CYCLES < 1 || DEAD_CYCLES >= (2 ** CNT_W) ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (2 ** CNT_W)) begin : g_bad_cfg
        $error("motor_seq: DEAD_CYCLES/TIMEOUT_CYCLES out of range for CNT_W");
    end

    state_t state;
    state_t state_nx;
    logic   req;
    logic   dead_start;
    logic   dead_done;

    assign req = l | u;

`ifdef MOTOR_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] run_cnt;
    logic             run_entry;
    logic             timeout;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // run_cnt is the index (from 0) of the current run cycle, so the limit
    // is hit during the TIMEOUT_CYCLES-th cycle of a run.
    assign run_entry = ((state_nx == RUN_R) || (state_nx == RUN_L)) && (state_nx != state);
    assign timeout   = (run_cnt >= TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt <= '0;
        end else if (run_entry) begin
            run_cnt <= '0;
        end else if ((state == RUN_R) || (state == RUN_L)) begin
            run_cnt <= sat_inc(run_cnt);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STOP;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            STOP: begin
                if (req && !fd) begin
                    state_nx = RUN_R;
                end else if (!req && !fe) begin
                    state_nx = RUN_L;
                end
            end
            RUN_R: begin
                // Exit conditions take priority over the timeout.
                if (fd || !req) begin
                    state_nx = DEAD;
`ifdef MOTOR_SEQ_TIMEOUT_EN
                end else if (timeout) begin
                    state_nx = FAULT;
`endif
                end
            end
            RUN_L: begin
                if (fe || req) begin
                    state_nx = DEAD;
`ifdef MOTOR_SEQ_TIMEOUT_EN
                end else if (timeout) begin
                    state_nx = FAULT;
`endif
                end
            end
            DEAD: begin
                if (dead_done) begin
                    state_nx = STOP;
                end
            end
            FAULT: begin
`ifdef MOTOR_SEQ_TIMEOUT_EN
                state_nx = FAULT;
`else
                state_nx = STOP;
`endif
            end
            default: state_nx = STOP;
        endcase
    end

    assign dead_start = (state_nx == DEAD) && (state != DEAD);

    dead_timer #(
        .DEAD_CYCLES(DEAD_CYCLES),
        .CNT_W      (CNT_W)
    ) u_dead_timer (
        .clk  (clk),
        .rst  (rst),
        .start(dead_start),
        .done (dead_done)
    );

    assign a    = (state == RUN_L);
    assign b    = (state == RUN_R);
    assign busy = (state == RUN_L) || (state == RUN_R) || (state == DEAD);
`ifdef MOTOR_SEQ_TIMEOUT_EN
    assign fault = (state == FAULT);
`else
    assign fault = 1'b0;
`endif

endmodule
